toast_timer: RTL

Receiving end of the toaster control handshake. Accepts the cook time (seconds) and heater duty cycle that the keypad controller publishes with `write`, and acknowledges with `write_ack`. Runs a 1 Hz m:ss countdown whose BCD value drives the display and the controller's time-recall path. Drives the heater element with a PWM output while toasting.

---
 rtl/toaster_pkg.sv | 49 ++++
 rtl/heater_pwm.sv | 52 +++++
 rtl/toast_timer.sv | 116 +++++++++++
 3 files changed

// File: rtl/toaster_pkg.sv
// Shared types and helpers for the toaster timer slice.
// Holds the FSM encoding, m:ss BCD bundle and conversion helpers.
package toaster_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int PWM_STEPS   = 100;
   localparam int MAX_SECONDS = 599;

   typedef struct packed {
      logic [3:0] mins;
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_mss_t;

   function automatic bcd_mss_t to_mss(input logic [9:0] secs);
      bcd_mss_t   v;
      logic [9:0] s;
      logic [5:0] r;
      s = (secs > 10'(MAX_SECONDS)) ? 10'(MAX_SECONDS) : secs;
      v.mins = 4'(s / 10'd60);
      r      = 6'(s % 10'd60);
      v.tens = 4'(r / 6'd10);
      v.ones = 4'(r % 6'd10);
      return v;
   endfunction

   function automatic bcd_mss_t mss_dec(input bcd_mss_t x);
      bcd_mss_t v;
      v = x;
      if (x.ones != 4'd0) begin
         v.ones = x.ones - 4'd1;
      end else begin
         v.ones = 4'd9;
         if (x.tens != 4'd0) begin
            v.tens = x.tens - 4'd1;
         end else begin
            v.tens = 4'd5;
            v.mins = x.mins - 4'd1;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/heater_pwm.sv
// Heater PWM: step divider, 100-step counter, duty double-buffer.
// Duty only changes at the period wrap so the drive never glitches.
module heater_pwm #(
   parameter int PWM_DIV = 500
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [6:0] duty_next,
   output logic       heat
);
   import toaster_pkg::*;

   localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;
   logic [6:0]    step_q;
   logic [6:0]    step_d;
   logic [6:0]    duty_q;
   logic [6:0]    duty_d;
   logic          adv;
   logic          wrap;

   // Next values of the free-running divider, step and duty buffer
   always_comb begin
      adv    = (div_q == DW'(PWM_DIV - 1));
      wrap   = adv && (step_q == 7'(PWM_STEPS - 1));
      div_d  = adv ? '0 : div_q + DW'(1);
      step_d = step_q;
      if (adv) begin
         step_d = wrap ? 7'd0 : step_q + 7'd1;
      end
      duty_d = wrap ? duty_next : duty_q;
   end

   // Registers; heat is aligned with the step and duty it reflects
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q  <= '0;
         step_q <= '0;
         duty_q <= '0;
         heat   <= 1'b0;
      end else begin
         div_q  <= div_d;
         step_q <= step_d;
         duty_q <= duty_d;
         heat   <= enable && (step_d < duty_d);
      end
   end

endmodule

// File: rtl/toast_timer.sv
// Toaster countdown timer: write handshake, m:ss BCD countdown,
// run/stop FSM and heater PWM drive.
module toast_timer #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int PWM_DIV = 500
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        write,
   input  logic [9:0]  Time,
   input  logic [7:0]  DC,
   output logic        write_ack,
   output logic [11:0] tLED,
   output logic        heat,
   output logic        busy,
   output logic        done
);
   import toaster_pkg::*;

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   state_t        state_q;
   state_t        state_d;
   bcd_mss_t      tled_q;
   bcd_mss_t      tled_d;
   bcd_mss_t      tled_ld;
   logic [PW-1:0] presc_q;
   logic [6:0]    duty_next_q;
   logic [6:0]    duty_clamp;
   logic          load;
   logic          tick;

   assign tLED = tled_q;

   // Load decode: post-load time value and clamped duty
   always_comb begin
      load       = write && !write_ack;
      tick       = (presc_q == PW'(CLK_HZ - 1));
      tled_ld    = load ? to_mss(Time) : tled_q;
      duty_clamp = (DC > 8'd100) ? 7'd100 : DC[6:0];
   end

   // Next state and countdown; a same-cycle load beats a tick
   always_comb begin
      state_d = state_q;
      tled_d  = tled_ld;
      unique case (state_q)
         IDLE: begin
            if (start && !stop && tled_ld != '0) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (!load && tick && tled_q != '0) begin
               tled_d = mss_dec(tled_q);
               if (tled_q == 12'h001) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Second prescaler, held clear outside RUN so a resume starts fresh
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
      end else if (state_q != RUN || tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // State, time, handshake and registered status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tled_q      <= '0;
         write_ack   <= 1'b0;
         duty_next_q <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q   <= state_d;
         tled_q    <= tled_d;
         write_ack <= write;
         busy      <= (state_d == RUN);
         done      <= (state_d == DONE);
         if (load) begin
            duty_next_q <= duty_clamp;
         end
      end
   end

   heater_pwm #(
      .PWM_DIV (PWM_DIV)
   ) u_pwm (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (state_d == RUN),
      .duty_next (duty_next_q),
      .heat      (heat)
   );

endmodule
